writeback_stage: RTL

Final pipeline stage of the in-order MIPS core. It latches the instruction handed over by the execute stage. For loads and stores it waits for the data-bus response (`data_data_ok`). For loads it extracts and extends the returned data (LB/LBU/LH/LHU/LW/LWL/LWR), then writes the register file. It also drives the WB forwarding port consumed by the execute stage and the NSCSCC trace-compare debug outputs.

---
 rtl/writeback_stage_if.sv | 24 ++
 rtl/writeback_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handoff bundle: one instruction offered per cycle, accepted on valid && ready.
interface writeback_stage_if #(
  parameter int unsigned CtrlW = 9
);
  logic             valid;
  logic [31:0]      pc;
  logic [31:0]      inst;
  logic [CtrlW-1:0] ctrl;
  logic [31:0]      result;
  logic [31:0]      eaddr;
  logic [31:0]      rdata2;
  logic [4:0]       waddr;
  logic             ready;

  modport master (
    output valid, pc, inst, ctrl, result, eaddr, rdata2, waddr,
    input  ready
  );

  modport slave (
    input  valid, pc, inst, ctrl, result, eaddr, rdata2, waddr,
    output ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final MIPS pipeline stage: holds one instruction, waits for the data-bus response on memory ops,
// extracts load data and drives the register-file write, WB forwarding and trace debug ports.
module writeback_stage (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             data_rdata,
  input  logic                    data_data_ok,
  writeback_stage_if.slave        ex_if,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [4:0]              wb_fwd_addr,
  output logic [31:0]             wb_fwd_data,
  output logic                    wb_fwd_ok,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  // Control-bit layout shared with the decoder; load-type bits are one-hot.
  localparam int unsigned CtrlW = 9;
  localparam int unsigned IMemR = 0;
  localparam int unsigned IMemW = 1;
  localparam int unsigned ILb   = 2;
  localparam int unsigned ILbu  = 3;
  localparam int unsigned ILh   = 4;
  localparam int unsigned ILhu  = 5;
  localparam int unsigned ILw   = 6;
  localparam int unsigned ILwl  = 7;
  localparam int unsigned ILwr  = 8;

  // StMem covers both WAIT and a memory op retiring on data_data_ok.
  typedef enum logic [1:0] {StEmpty, StAlu, StMem} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [31:0]      result_q, result_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata2_q, rdata2_d;
  logic [4:0]       waddr_q, waddr_d;

  logic        valid;
  logic        retire;
  logic        ready;
  logic        accept;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  shl;
  logic [4:0]  shr;
  logic [31:0] wdata;

  always_comb begin
    valid  = (state_q != StEmpty);
    retire = valid && ((state_q != StMem) || data_data_ok);
    ready  = !valid || retire;
    accept = ex_if.valid && ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StEmpty;
      pc_q     <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      off_q    <= '0;
      rdata2_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      off_q    <= off_d;
      rdata2_q <= rdata2_d;
      waddr_q  <= waddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    off_d    = off_q;
    rdata2_d = rdata2_q;
    waddr_d  = waddr_q;
    if (accept) begin
      state_d  = (ex_if.ctrl[IMemR] || ex_if.ctrl[IMemW]) ? StMem : StAlu;
      pc_d     = ex_if.pc;
      ctrl_d   = ex_if.ctrl;
      result_d = ex_if.result;
      off_d    = ex_if.eaddr[1:0];
      rdata2_d = ex_if.rdata2;
      waddr_d  = ex_if.waddr;
    end else if (retire) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    byte_v = 8'(data_rdata >> {off_q, 3'b000});
    half_v = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    // 8*(3-o) equals {~o, 3'b0} for a 2-bit offset.
    shl    = {~off_q, 3'b000};
    shr    = {off_q, 3'b000};
    wdata  = result_q;
    if (ctrl_q[IMemR]) begin
      if (ctrl_q[ILb]) begin
        wdata = {{24{byte_v[7]}}, byte_v};
      end else if (ctrl_q[ILbu]) begin
        wdata = {24'h0, byte_v};
      end else if (ctrl_q[ILh]) begin
        wdata = {{16{half_v[15]}}, half_v};
      end else if (ctrl_q[ILhu]) begin
        wdata = {16'h0, half_v};
      end else if (ctrl_q[ILw]) begin
        wdata = data_rdata;
      end else if (ctrl_q[ILwl]) begin
        wdata = (data_rdata << shl) | (rdata2_q & ~(32'hffffffff << shl));
      end else if (ctrl_q[ILwr]) begin
        wdata = (data_rdata >> shr) | (rdata2_q & ~(32'hffffffff >> shr));
      end
    end

    ex_if.ready       = ready;
    rf_we             = retire && (waddr_q != 5'd0);
    rf_waddr          = waddr_q;
    rf_wdata          = wdata;
    wb_fwd_addr       = valid ? waddr_q : 5'd0;
    wb_fwd_data       = wdata;
    wb_fwd_ok         = valid && (!ctrl_q[IMemR] || data_data_ok);
    debug_wb_pc       = pc_q;
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = waddr_q;
    debug_wb_rf_wdata = wdata;
  end

`ifndef SYNTHESIS
  // A response with no memory op held is dropped; flag it as a bus protocol error.
  stray_data_ok_a : assert property (@(posedge clk) disable iff (!resetn)
    data_data_ok |-> (state_q == StMem))
    else $error("data_data_ok with no memory op held");
`endif

endmodule
